aes_round_back: RTL and testbench

AES_ROUND_BACK -- requirements
Module: aes_round_back

---
 rtl/aes_round_back_pkg.sv | 34 +++
 rtl/aes_mix_column.sv | 21 ++
 rtl/aes_round_back.sv | 91 +++++++++
 tb/tb_aes_round_back.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_round_back_pkg.sv
// Shared AES helpers: GF(2^8) doubling/tripling, ShiftRows byte map and the 128-bit state type.
// Byte k of a state sits at bits [127-8k -: 8], with k = 4*column + row.
package aes_round_back_pkg;

    typedef logic [127:0] aes_state_t;

    // Output byte k of ShiftRows is taken from input byte SR_IDX[k].
    localparam int SR_IDX [16] = '{ 0,  5, 10, 15,
                                    4,  9, 14,  3,
                                    8, 13,  2,  7,
                                   12,  1,  6, 11};

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gf_mul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    function automatic aes_state_t shift_rows(input aes_state_t s);
        aes_state_t r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[127-8*k -: 8] = s[127-8*SR_IDX[k] -: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_mix_column.sv
// MixColumns on one 32-bit column; row 0 byte in [31:24], row 3 byte in [7:0].
module aes_mix_column
    import aes_round_back_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col_in[31:24];
    assign a1 = col_in[23:16];
    assign a2 = col_in[15:8];
    assign a3 = col_in[7:0];

    assign col_out[31:24] = gf_mul2(a0) ^ gf_mul3(a1) ^ a2 ^ a3;
    assign col_out[23:16] = a0 ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
    assign col_out[15:8]  = a0 ^ a1 ^ gf_mul2(a2) ^ gf_mul3(a3);
    assign col_out[7:0]   = gf_mul3(a0) ^ a1 ^ a2 ^ gf_mul2(a3);

endmodule

// File: rtl/aes_round_back.sv
// Back half of an AES round (ShiftRows, MixColumns, AddRoundKey) behind a 1-cycle valid/ready stage.
// Define AES_ROUND_SKID_EN to add a one-entry skid register and a registered in_ready.
module aes_round_back
    import aes_round_back_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         out_last
);

    aes_state_t sr_state;
    aes_state_t mc_state;
    aes_state_t round_res;
    logic       in_fire;

    assign sr_state = shift_rows(in_state);

    for (genvar c = 0; c < 4; c++) begin : g_col
        aes_mix_column u_mix (
            .col_in  (sr_state[127-32*c -: 32]),
            .col_out (mc_state[127-32*c -: 32])
        );
    end

    assign round_res = (in_last ? sr_state : mc_state) ^ in_key;
    assign in_fire   = in_valid && in_ready;

`ifdef AES_ROUND_SKID_EN
    logic       skid_valid;
    aes_state_t skid_state;
    logic       skid_last;
    logic       out_free;

    // in_ready is the skid-empty flop; the rst gate only forces 0 during the reset cycle itself.
    assign in_ready = !skid_valid && !rst;
    assign out_free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_state  <= '0;
            out_last   <= 1'b0;
            skid_valid <= 1'b0;
            skid_state <= '0;
            skid_last  <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_state  <= skid_state;
                out_last   <= skid_last;
                skid_valid <= 1'b0;
            end else if (in_fire) begin
                out_valid <= 1'b1;
                out_state <= round_res;
                out_last  <= in_last;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (in_fire) begin
            skid_valid <= 1'b1;
            skid_state <= round_res;
            skid_last  <= in_last;
        end
    end
`else
    assign in_ready = (!out_valid || out_ready) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_state <= '0;
            out_last  <= 1'b0;
        end else if (in_fire) begin
            out_valid <= 1'b1;
            out_state <= round_res;
            out_last  <= in_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_aes_round_back.sv
// Scoreboard bench for aes_round_back: random and FIPS-197 beats against a byte-matrix AES model.
module tb_aes_round_back;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         out_last;

`ifdef AES_ROUND_SKID_EN
    localparam int HELD_MAX = 2;
`else
    localparam int HELD_MAX = 1;
`endif

    typedef struct {
        logic [127:0] st;
        logic         last;
    } exp_t;

    exp_t         exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           n_acc    = 0;
    int           n_out    = 0;
    bit           rand_ready = 1'b0;
    logic         prev_stall = 1'b0;
    logic [127:0] prev_state;
    logic         prev_last;

    aes_round_back dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] key,
                                               input logic last);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   m [4][4];
        logic [127:0] res;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = st[127-8*(4*c+r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r][c] = s[r][(c+r)%4];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = last ? t[r][c]
                               : gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                                 ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = m[r][c];
        return res ^ key;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pushes on input transfers, pops/compares on output transfers, watches stall stability.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_stall) begin
                chk("stall_valid", {127'd0, out_valid}, 128'd1);
                chk("stall_state", out_state, prev_state);
                chk("stall_last", {127'd0, out_last}, {127'd0, prev_last});
            end
            if (in_valid && in_ready) begin
                exp_q.push_back('{st: ref_round(in_state, in_key, in_last), last: in_last});
                n_acc++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", out_state, 128'hx);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_state", out_state, e.st);
                    chk("out_last", {127'd0, out_last}, {127'd0, e.last});
                end
            end
        end
        prev_stall = !rst && out_valid && !out_ready;
        prev_state = out_state;
        prev_last  = out_last;
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic send_beat(input logic [127:0] st, input logic [127:0] key, input logic last);
        int w;
        in_state = st; in_key = key; in_last = last; in_valid = 1'b1;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) chk("send_timeout", {127'd0, in_ready}, 128'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drive_random();
        in_state = {$urandom, $urandom, $urandom, $urandom};
        in_key   = {$urandom, $urandom, $urandom, $urandom};
        in_last  = 1'($urandom_range(0, 3) == 0);
    endtask

    task automatic drain();
        int w;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        w = 0;
        while ((exp_q.size() != 0 || out_valid) && w < 500) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain_empty", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a0;
        int o0;
        int held;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_state = '0; in_key = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {127'd0, in_ready}, 128'd0);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_out_state", out_state, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", {127'd0, in_ready}, 128'd1);
        @(posedge clk); #1;

        // FIPS-197 Appendix B round 1, with a 1-cycle latency check
        out_ready = 1'b1;
        send_beat(128'hd42711aee0bf98f1b8b45de51e415230, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0);
        @(negedge clk);
        chk("fips_r1_valid", {127'd0, out_valid}, 128'd1);
        chk("fips_r1_state", out_state, 128'ha49c7ff2689f352b6b5bea43026a5049);
        @(posedge clk); #1;

        send_beat(128'hd42711aee0bf98f1b8b45de51e415230, 128'd0, 1'b1);
        @(negedge clk);
        chk("last_state", out_state, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        chk("last_flag", {127'd0, out_last}, 128'd1);
        @(posedge clk); #1;

        // Bytes placed so that column 0 after ShiftRows is db135345
        send_beat(128'hdb00_0000_0013_0000_0000_5300_0000_0045, 128'd0, 1'b0);
        @(negedge clk);
        chk("mixcol_state", out_state, {32'h8e4da1bc, 96'd0});
        @(posedge clk); #1;

        // Backpressure: 8 back-to-back beats, random out_ready
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive_random();
            send_beat(in_state, in_key, in_last);
        end
        drain();

        // Stalled output: count beats absorbed before in_ready drops
        out_ready = 1'b0;
        a0 = n_acc;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive_random();
            @(posedge clk); #1;
        end
        held = n_acc - a0;
        chk("held_beats", 128'(held), 128'(HELD_MAX));
        chk("stalled_in_ready", {127'd0, in_ready}, 128'd0);

        // Reset mid-stream while stalled and full; the accepted beats must vanish
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {127'd0, in_ready}, 128'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("midrst_out_state", out_state, 128'd0);
        chk("midrst_out_last", {127'd0, out_last}, 128'd0);
        chk("midrst_in_ready_after", {127'd0, in_ready}, 128'd1);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Streaming: 16 beats on 16 consecutive edges, 16 results right behind them
        a0 = n_acc; o0 = n_out;
        drive_random();
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (i < 15) drive_random();
        end
        in_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        chk("stream_accepted", 128'(n_acc - a0), 128'd16);
        chk("stream_outputs", 128'(n_out - o0), 128'd16);

        // Random traffic with gaps and random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end else begin
                drive_random();
                send_beat(in_state, in_key, in_last);
            end
        end
        drain();
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
